// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control FSM driving datapath selects and enables
module mc_controller #(
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [5:0]     op,
  input  logic [5:0]     funct,
  input  logic           zero,
  output logic           pcen,
  output logic           irwrite,
  output logic           memwrite,
  output logic           regwrite,
  output logic           iord,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic           memtoreg,
  output logic           regdst,
  output logic [1:0]     pcsrc,
  output logic [2:0]     alucontrol,
  output logic           immext,
  output logic [STW-1:0] state,
  output logic           done
);
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                         OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_SLTI = 6'b001010,
                         OP_J = 6'b000010;
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXECUTE = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, IEXE = 4'd9, IWB = 4'd10, JUMP = 4'd11
  } state_t;
  state_t cur, nxt;
  logic [2:0] falu, ialu;
  logic fvalid, iimm;
  logic pcen_s, irwrite_s, memwrite_s, regwrite_s, done_s;
  always_ff @(posedge clk) cur <= reset ? FETCH : nxt;
  always_comb begin
    falu = 3'b010;
    fvalid = 1'b1;
    case (funct)
      6'b100000: falu = 3'b010;
      6'b100010: falu = 3'b110;
      6'b100100: falu = 3'b000;
      6'b100101: falu = 3'b001;
      6'b101010: falu = 3'b111;
      default:   fvalid = 1'b0;
    endcase
  end
  always_comb begin
    ialu = 3'b010;
    iimm = 1'b0;
    case (op)
      OP_ANDI: begin ialu = 3'b000; iimm = 1'b1; end
      OP_ORI:  begin ialu = 3'b001; iimm = 1'b1; end
      OP_SLTI: ialu = 3'b111;
      default: ialu = 3'b010;
    endcase
  end
  always_comb begin
    nxt = FETCH;
    {pcen_s, irwrite_s, memwrite_s, regwrite_s, done_s} = '0;
    {iord, alusrca, alusrcb, memtoreg, regdst, pcsrc, alucontrol, immext} = '0;
    case (cur)
      FETCH: begin
        nxt = DECODE;
        alusrcb = 2'b01;
        alucontrol = 3'b010;
        irwrite_s = 1'b1;
        pcen_s = 1'b1;
      end
      DECODE: begin
        alusrcb = 2'b11;
        alucontrol = 3'b010;
        case (op)
          OP_LW, OP_SW:                      nxt = MEMADR;
          OP_R:                              nxt = fvalid ? EXECUTE : FETCH;
          OP_BEQ, OP_BNE:                    nxt = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt = IEXE;
          OP_J:                              nxt = JUMP;
          default:                           nxt = FETCH;
        endcase
      end
      MEMADR: begin
        nxt = (op == OP_LW) ? MEMRD : MEMWR;
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alucontrol = 3'b010;
      end
      MEMRD: begin
        nxt = MEMWB;
        iord = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite_s = 1'b1;
        done_s = 1'b1;
      end
      MEMWR: begin
        iord = 1'b1;
        memwrite_s = 1'b1;
        done_s = 1'b1;
      end
      EXECUTE: begin
        nxt = ALUWB;
        alusrca = 1'b1;
        alucontrol = falu;
      end
      ALUWB: begin
        regdst = 1'b1;
        regwrite_s = 1'b1;
        done_s = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        alucontrol = 3'b110;
        pcsrc = 2'b01;
        pcen_s = ((op == OP_BEQ) & zero) | ((op == OP_BNE) & ~zero);
        done_s = 1'b1;
      end
      IEXE: begin
        nxt = IWB;
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alucontrol = ialu;
        immext = iimm;
      end
      IWB: begin
        regwrite_s = 1'b1;
        done_s = 1'b1;
      end
      JUMP: begin
        pcsrc = 2'b10;
        pcen_s = 1'b1;
        done_s = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end
  // Strobes are masked during reset so a half-finished instruction cannot commit
  assign pcen = pcen_s & ~reset;
  assign irwrite = irwrite_s & ~reset;
  assign memwrite = memwrite_s & ~reset;
  assign regwrite = regwrite_s & ~reset;
  assign done = done_s & ~reset;
  assign state = STW'(cur);
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control unit that sits directly upstream of the multicycle MIPS datapath and drives all of its select and enable inputs.
- A Moore FSM decodes op/funct from the instruction register and sequences fetch, decode, execute, memory and writeback.
- It also produces irwrite and memwrite for the instruction register and the memory/IO block.
- Supported instructions: R-type add/sub/and/or/slt, lw, sw, beq, bne, addi, andi, ori, slti, j.

Parameters:
STW, 4, width of the state debug output (must be >= 4)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; state -> FETCH
op  input  6  instr[31:26] from instruction register
funct  input  6  instr[5:0]
zero  input  1  ALU zero flag (combinational, current cycle)
pcen  output  1  PC register enable
irwrite  output  1  instruction register load
memwrite  output  1  memory/IO write strobe
regwrite  output  1  register file write
iord  output  1  0 = PC, 1 = aluout as memory address
alusrca  output  1  0 = PC, 1 = A
alusrcb  output  2  00 = B, 01 = 4, 10 = imm, 11 = imm<<2
memtoreg  output  1  0 = aluout, 1 = mem data
regdst  output  1  0 = rt, 1 = rd
pcsrc  output  2  00 = aluresult, 01 = aluout, 10 = jump target
alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
immext  output  1  0 = sign-extend, 1 = zero-extend
state  output  STW  current state code (debug/LED)
done  output  1  one-cycle pulse in the last cycle of each instruction

Behaviour:
- State register: the only storage. Reset synchronous; while reset=1, pcen/irwrite/memwrite/regwrite/done are forced 0. The first edge with reset=1 loads FETCH (0).
- All outputs are combinational from state, except:
  - pcen in BRANCH depends on zero and op.
  - alucontrol/immext in EXECUTE and IEXE depend on funct/op.
- Unlisted outputs in any state are 0. Output defaults in every state: memwrite=0, regwrite=0.
- State encodings and per-state outputs:
  - FETCH=0: iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, irwrite=1, pcen=1.
  - DECODE=1: alusrca=0, alusrcb=11, alucontrol=010 (branch target into aluout).
  - MEMADR=2: alusrca=1, alusrcb=10, alucontrol=010, immext=0.
  - MEMRD=3: iord=1.
  - MEMWB=4: regdst=0, memtoreg=1, regwrite=1, done=1.
  - MEMWR=5: iord=1, memwrite=1, done=1.
  - EXECUTE=6: alusrca=1, alusrcb=00, alucontrol from funct.
  - ALUWB=7: regdst=1, memtoreg=0, regwrite=1, done=1.
  - BRANCH=8: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, pcen=(op==beq & zero)|(op==bne & ~zero), done=1.
  - IEXE=9: alusrca=1, alusrcb=10, alucontrol/immext from op.
  - IWB=10: regdst=0, memtoreg=0, regwrite=1, done=1.
  - JUMP=11: pcsrc=10, pcen=1, done=1.
- Transitions:
  - FETCH->DECODE.
  - DECODE by op:
    - 100011 or 101011 -> MEMADR.
    - 000000 with valid funct -> EXECUTE.
    - 000100/000101 -> BRANCH.
    - 001000/001100/001101/001010 -> IEXE.
    - 000010 -> JUMP.
    - Anything else, including R-type with unknown funct -> FETCH (instruction skipped, no writes, no done).
  - MEMADR: lw->MEMRD, sw->MEMWR.
  - MEMRD->MEMWB.
  - EXECUTE->ALUWB.
  - IEXE->IWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, IWB, JUMP -> FETCH.
  - Codes 12-15 (unreachable) -> FETCH with all outputs 0.
- funct decode: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
- op decode in IEXE:
  - addi 010, immext=0.
  - andi 000, immext=1.
  - ori 001, immext=1.
  - slti 111, immext=0.
- Latency in cycles including FETCH:
  - lw 5.
  - sw, R-type, I-type ALU 4.
  - beq/bne, j 3.
  - Undefined op 2.
- op/funct are sampled only in DECODE/MEMADR/EXECUTE/IEXE/BRANCH. They must be stable from the instruction register after FETCH.
- Reset asserted mid-instruction: the next edge returns to FETCH. No write strobe is asserted in the reset cycle, even if the state is MEMWR/ALUWB.

Test Plan:
- Reset held 2 cycles then released → state=0, pcen=irwrite=1 on the first post-reset cycle; all strobes 0 while reset=1.
- lw (op=100011) → state sequence 0,1,2,3,4,0; MEMRD iord=1; MEMWB regwrite=1, memtoreg=1, done=1 for exactly one cycle.
- R-type sub (funct=100010) then slt (101010) → EXECUTE alucontrol=110 then 111; ALUWB regdst=1, regwrite=1; 4 cycles each.
- beq with zero=1 and zero=0, bne with zero=0 → BRANCH pcen=1, 0, 1 respectively; pcsrc=01, alucontrol=110.
- ori (001101) and addi (001000) → IEXE immext=1, alucontrol=001, then immext=0, alucontrol=010; IWB regdst=0, regwrite=1. j (000010) → JUMP pcsrc=10, pcen=1.
- Illegal op 111111 and R-type funct 000000 → DECODE→FETCH, no regwrite/memwrite/done. sw with reset asserted in MEMWR → memwrite=0, state 0 on next edge.
